// File: rtl/text_line_fetcher_pkg.sv
// ---------------------------------------------------------------------------
// text_line_fetcher_pkg
// Shared types and constants for the text line fetcher and its line buffer.
// The console geometry macros are shared with the text-editing side. They are
// only given fallback values here when no other file has defined them first.
// Optional feature macro used by this slice: TEXT_CURSOR_OVERLAY_EN.
// ---------------------------------------------------------------------------
`ifndef CONSOLE_COLUMNS
`define CONSOLE_COLUMNS 80
`endif
`ifndef CONSOLE_CHAR_WIDTH
`define CONSOLE_CHAR_WIDTH 32
`endif

package text_line_fetcher_pkg;

    localparam int DEFAULT_COLUMNS    = `CONSOLE_COLUMNS;
    localparam int DEFAULT_CHAR_WIDTH = `CONSOLE_CHAR_WIDTH;

    // Space character with the default console attribute, shown for rows
    // that lie outside the text RAM.
    localparam logic [31:0] BLANK_CELL = 32'h0007fc20;

    // Attribute bit that renders a cell in reverse video.
    localparam int TEXT_ATTR_REVERSE_BIT = 31;

    typedef enum logic [1:0] {
        F_IDLE,
        F_ISSUE,
        F_WAIT,
        F_CAPTURE
    } fetch_state_t;

    typedef struct packed {
        logic [7:0] row;
    } LineReq_t;

    typedef struct packed {
        logic [23:0] attr;
        logic [7:0]  code;
    } Cell_t;

endpackage

// File: rtl/text_line_fetcher_line_buffer_2x.sv
// ---------------------------------------------------------------------------
// line_buffer_2x
// This module holds two line registers. The back buffer is filled by the fetch
// FSM. The front buffer is streamed cell by cell to the renderer.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   capture, capture_line,    load the back buffer with a whole row and its
//   capture_row               row tag
//   accept                    renderer handshake (cell_ready)
//   back_full                 back buffer holds a row that is not yet swapped
//   cell_valid/data/col/row/last  current cell of the front buffer
// ---------------------------------------------------------------------------
module line_buffer_2x #(
    parameter int COLUMNS    = 80,
    parameter int CHAR_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          capture,
    input  logic [COLUMNS*CHAR_WIDTH-1:0] capture_line,
    input  logic [7:0]                    capture_row,
    input  logic                          accept,
    output logic                          back_full,
    output logic                          cell_valid,
    output logic [CHAR_WIDTH-1:0]         cell_data,
    output logic [7:0]                    cell_col,
    output logic [7:0]                    cell_row,
    output logic                          cell_last
);

    localparam logic [7:0] LAST_COL = 8'(COLUMNS - 1);

    logic [COLUMNS*CHAR_WIDTH-1:0] front_line;
    logic [COLUMNS*CHAR_WIDTH-1:0] back_line;
    logic [7:0]                    front_row;
    logic [7:0]                    back_row;
    logic                          front_full;
    logic [7:0]                    col;
    logic                          last_accept;
    logic                          do_swap;

    // The swap may happen in the same cycle as the last cell is accepted.
    // This lets two rows follow each other without an empty cycle.
    assign last_accept = front_full && accept && (col == LAST_COL);
    assign do_swap     = back_full && (!front_full || last_accept);

    // Back buffer: the FSM only captures while it is empty, so capture and
    // swap never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            back_full <= 1'b0;
            back_row  <= 8'd0;
        end else if (capture) begin
            back_line <= capture_line;
            back_row  <= capture_row;
            back_full <= 1'b1;
        end else if (do_swap) begin
            back_full <= 1'b0;
        end
    end

    // Front buffer and column counter. The column moves on only when the
    // renderer accepts, so the outputs hold steady while it stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            front_full <= 1'b0;
            front_row  <= 8'd0;
            col        <= 8'd0;
        end else if (do_swap) begin
            front_line <= back_line;
            front_row  <= back_row;
            front_full <= 1'b1;
            col        <= 8'd0;
        end else if (last_accept) begin
            front_full <= 1'b0;
            col        <= 8'd0;
        end else if (front_full && accept) begin
            col <= col + 8'd1;
        end
    end

    // Outputs are gated with front_full so an empty buffer presents all zeros.
    assign cell_valid = front_full;
    assign cell_col   = col;
    assign cell_row   = front_full ? front_row : 8'd0;
    assign cell_last  = front_full && (col == LAST_COL);
    assign cell_data  = front_full ? front_line[CHAR_WIDTH*int'(col) +: CHAR_WIDTH]
                                   : '0;

endmodule

// File: rtl/text_line_fetcher.sv
// ---------------------------------------------------------------------------
// text_line_fetcher
// This block sits on the text RAM read port. It fetches one character row per
// line_req into a double-buffered line store. It then streams the cells to the
// glyph renderer with a valid/ready handshake.
// Optional feature macro: TEXT_CURSOR_OVERLAY_EN. When it is defined, the cell
// under the cursor is shown with its reverse-video attribute bit inverted.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   line_req, line_row            request to fetch a row (one-cycle pulse)
//   req_overrun                   pulse: a request was dropped (slot busy)
//   ram_addr, ram_rden, ram_q     text RAM read port
//   cell_valid/ready/data/col/row/last   cell stream to the renderer
//   cursor_row, cursor_col, cursor_on    cursor position (overlay only)
// ---------------------------------------------------------------------------
module text_line_fetcher
    import text_line_fetcher_pkg::*;
#(
    parameter int COLUMNS     = DEFAULT_COLUMNS,
    parameter int ROWS        = 50,
    parameter int CHAR_WIDTH  = DEFAULT_CHAR_WIDTH,
    parameter int RAM_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          line_req,
    input  logic [7:0]                    line_row,
    output logic                          req_overrun,
    output logic [7:0]                    ram_addr,
    output logic                          ram_rden,
    input  logic [COLUMNS*CHAR_WIDTH-1:0] ram_q,
    output logic                          cell_valid,
    input  logic                          cell_ready,
    output logic [CHAR_WIDTH-1:0]         cell_data,
    output logic [7:0]                    cell_col,
    output logic [7:0]                    cell_row,
    output logic                          cell_last,
    input  logic [7:0]                    cursor_row,
    input  logic [7:0]                    cursor_col,
    input  logic                          cursor_on
);

    localparam logic [7:0] ROW_LIMIT = 8'(ROWS);
    localparam logic [7:0] WAIT_LAST = 8'((RAM_LATENCY > 1) ? RAM_LATENCY - 2 : 0);

    fetch_state_t                  state;
    LineReq_t                      slot;
    logic                          slot_full;
    logic                          slot_take;
    logic [7:0]                    fetch_row;
    logic                          fetch_blank;
    logic [7:0]                    wait_cnt;
    logic                          back_full;
    logic                          capture;
    logic [COLUMNS*CHAR_WIDTH-1:0] capture_line;
    logic [CHAR_WIDTH-1:0]         buf_data;

    // The FSM takes the pending request when it leaves F_IDLE. A new request
    // in that same cycle can therefore refill the slot.
    assign slot_take = (state == F_IDLE) && slot_full && !back_full;

    // Single-entry request slot. A request that arrives while the slot is
    // still occupied is dropped and reported one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full   <= 1'b0;
            slot.row    <= 8'd0;
            req_overrun <= 1'b0;
        end else begin
            req_overrun <= 1'b0;
            if (line_req && (!slot_full || slot_take)) begin
                slot.row  <= line_row;
                slot_full <= 1'b1;
            end else begin
                if (slot_take) begin
                    slot_full <= 1'b0;
                end
                if (line_req) begin
                    req_overrun <= 1'b1;
                end
            end
        end
    end

    // Fetch FSM. ram_rden and ram_addr are registered, so they are valid for
    // exactly the one F_ISSUE cycle. For a row beyond the RAM there is no read;
    // the FSM goes straight to F_CAPTURE and loads blank cells instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= F_IDLE;
            ram_rden    <= 1'b0;
            ram_addr    <= 8'd0;
            fetch_row   <= 8'd0;
            fetch_blank <= 1'b0;
            wait_cnt    <= 8'd0;
        end else begin
            ram_rden <= 1'b0;
            ram_addr <= 8'd0;
            case (state)
                F_IDLE: begin
                    if (slot_take) begin
                        state       <= F_ISSUE;
                        fetch_row   <= slot.row;
                        fetch_blank <= (slot.row >= ROW_LIMIT);
                        if (slot.row < ROW_LIMIT) begin
                            ram_rden <= 1'b1;
                            ram_addr <= slot.row;
                        end
                    end
                end
                F_ISSUE: begin
                    wait_cnt <= 8'd0;
                    if (fetch_blank || (RAM_LATENCY == 1)) begin
                        state <= F_CAPTURE;
                    end else begin
                        state <= F_WAIT;
                    end
                end
                F_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= F_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                F_CAPTURE: begin
                    state <= F_IDLE;
                end
                default: begin
                    state <= F_IDLE;
                end
            endcase
        end
    end

    assign capture      = (state == F_CAPTURE);
    assign capture_line = fetch_blank ? {COLUMNS{BLANK_CELL}} : ram_q;

    line_buffer_2x #(
        .COLUMNS    (COLUMNS),
        .CHAR_WIDTH (CHAR_WIDTH)
    ) u_line_buffer (
        .clk          (clk),
        .rst          (rst),
        .capture      (capture),
        .capture_line (capture_line),
        .capture_row  (fetch_row),
        .accept       (cell_ready),
        .back_full    (back_full),
        .cell_valid   (cell_valid),
        .cell_data    (buf_data),
        .cell_col     (cell_col),
        .cell_row     (cell_row),
        .cell_last    (cell_last)
    );

`ifdef TEXT_CURSOR_OVERLAY_EN
    localparam int REV_ATTR_IDX = TEXT_ATTR_REVERSE_BIT - 8;

    Cell_t shown;

    // The cursor overlay is applied only on the way out; the stored line is
    // not changed.
    always_comb begin
        shown = Cell_t'(buf_data);
        if (cursor_on && cell_valid && (cell_row == cursor_row) && (cell_col == cursor_col)) begin
            shown.attr[REV_ATTR_IDX] = ~shown.attr[REV_ATTR_IDX];
        end
    end

    assign cell_data = shown;
`else
    logic unused_cursor;

    assign unused_cursor = ^{cursor_on, cursor_row, cursor_col};
    assign cell_data     = buf_data;
`endif

endmodule

// File: tb/tb_text_line_fetcher.sv
// ---------------------------------------------------------------------------
// tb_text_line_fetcher
// Scoreboard bench for text_line_fetcher. Each accepted request pushes the 80
// expected cells of its row, taken from the bench's own RAM image. A negedge
// monitor pops and compares every accepted cell. It also checks that a stalled
// cell stays stable.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_text_line_fetcher;
    import text_line_fetcher_pkg::*;

    localparam int COLUMNS     = 80;
    localparam int ROWS        = 50;
    localparam int CHAR_WIDTH  = 32;
    localparam int RAM_LATENCY = 2;
    localparam int LINE_W      = COLUMNS * CHAR_WIDTH;

    logic              clk = 1'b0;
    logic              rst;
    logic              line_req;
    logic [7:0]        line_row;
    logic              req_overrun;
    logic [7:0]        ram_addr;
    logic              ram_rden;
    logic [LINE_W-1:0] ram_q;
    logic              cell_valid;
    logic              cell_ready;
    logic [31:0]       cell_data;
    logic [7:0]        cell_col;
    logic [7:0]        cell_row;
    logic              cell_last;
    logic [7:0]        cursor_row;
    logic [7:0]        cursor_col;
    logic              cursor_on;

    text_line_fetcher #(
        .COLUMNS     (COLUMNS),
        .ROWS        (ROWS),
        .CHAR_WIDTH  (CHAR_WIDTH),
        .RAM_LATENCY (RAM_LATENCY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .line_req    (line_req),
        .line_row    (line_row),
        .req_overrun (req_overrun),
        .ram_addr    (ram_addr),
        .ram_rden    (ram_rden),
        .ram_q       (ram_q),
        .cell_valid  (cell_valid),
        .cell_ready  (cell_ready),
        .cell_data   (cell_data),
        .cell_col    (cell_col),
        .cell_row    (cell_row),
        .cell_last   (cell_last),
        .cursor_row  (cursor_row),
        .cursor_col  (cursor_col),
        .cursor_on   (cursor_on)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bench RAM image: ROWS rows of COLUMNS cells.
    logic [31:0]       mem [ROWS][COLUMNS];
    logic [LINE_W-1:0] ram_pipe [RAM_LATENCY];

    // RAM model: the read strobe is sampled on a clock edge and the data
    // appears RAM_LATENCY edges later. When no read is issued, the pipe carries
    // junk, so a capture at the wrong moment is visible.
    always @(posedge clk) begin
        logic [LINE_W-1:0] word;
        for (int c = 0; c < COLUMNS; c++) begin
            if (ram_rden && (ram_addr < ROWS)) word[c*32 +: 32] = mem[ram_addr][c];
            else                              word[c*32 +: 32] = $urandom;
        end
        ram_pipe[0] <= word;
        for (int i = 1; i < RAM_LATENCY; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign ram_q = ram_pipe[RAM_LATENCY-1];

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  col;
        logic [7:0]  row;
        logic        last;
    } cell_exp_t;

    cell_exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int rden_count = 0;
    int overrun_count = 0;
    int ready_mode = 1;

    // Expected row contents come from the bench RAM image. Out-of-range rows
    // are blank. The cursor cell is reverse-video when the overlay is built in.
    function automatic void push_row(input int row);
        for (int c = 0; c < COLUMNS; c++) begin
            cell_exp_t e;
            if (row < ROWS) e.data = mem[row][c];
            else            e.data = BLANK_CELL;
`ifdef TEXT_CURSOR_OVERLAY_EN
            if (cursor_on && (row == int'(cursor_row)) && (c == int'(cursor_col)))
                e.data[31] = ~e.data[31];
`endif
            e.col  = 8'(c);
            e.row  = 8'(row);
            e.last = (c == COLUMNS - 1);
            exp_q.push_back(e);
        end
    endfunction

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one line_req pulse. Call it at posedge+#1. It returns at posedge+#1
    // after the edge that sampled the request.
    task automatic applyStimulus(input int row, input bit expect_kept);
        line_req = 1'b1;
        line_row = 8'(row);
        if (expect_kept) push_row(row);
        @(posedge clk);
        #1;
        line_req = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || cell_valid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, 64'(exp_q.size()), 64'd0);
    endtask

    // cell_ready driver: 0 = held low, 1 = held high, 2 = toggling,
    // 3 = random (about 75% high).
    initial begin
        cell_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       cell_ready = 1'b0;
                1:       cell_ready = 1'b1;
                2:       cell_ready = ~cell_ready;
                default: cell_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: scoreboard pops, stall stability, RAM strobe and overrun counts.
    logic        prev_hold = 1'b0;
    logic [63:0] prev_snap = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold)
                checkOutput("hold_stable", 64'({cell_valid, cell_data, cell_col, cell_row, cell_last}),
                            prev_snap);
            if (ram_rden) begin
                rden_count++;
                checkOutput("rden_addr_in_range", 64'(ram_addr < ROWS), 64'd1);
            end
            if (req_overrun) overrun_count++;
            if (cell_valid && cell_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_cell", 64'(exp_q.size()), 64'd1);
                end else begin
                    cell_exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("cell", 64'({cell_data, cell_col, cell_row, cell_last}), 64'(e));
                end
            end
            prev_hold <= cell_valid && !cell_ready;
            prev_snap <= 64'({1'b1, cell_data, cell_col, cell_row, cell_last});
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_outputs_zero(input string tag);
        checkOutput({tag, "_valid"},   64'(cell_valid),  64'd0);
        checkOutput({tag, "_data"},    64'(cell_data),   64'd0);
        checkOutput({tag, "_col"},     64'(cell_col),    64'd0);
        checkOutput({tag, "_row"},     64'(cell_row),    64'd0);
        checkOutput({tag, "_last"},    64'(cell_last),   64'd0);
        checkOutput({tag, "_rden"},    64'(ram_rden),    64'd0);
        checkOutput({tag, "_addr"},    64'(ram_addr),    64'd0);
        checkOutput({tag, "_overrun"}, 64'(req_overrun), 64'd0);
    endtask

    initial begin
        int base;
        int req_cyc;
        int n;
        int row;
        bit found;

        rst        = 1'b1;
        line_req   = 1'b0;
        line_row   = 8'd0;
        cursor_row = 8'd0;
        cursor_col = 8'd0;
        cursor_on  = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLUMNS; c++)
                mem[r][c] = (r == 3) ? (32'h41 + 32'(c)) : $urandom;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("[TB] reset released");

        // Row 3 with ready high. The latency is counted from the edge that
        // samples line_req to the edge after which cell_valid is first high.
        ready_mode = 1;
        @(posedge clk);
        #1;
        base    = rden_count;
        req_cyc = cyc + 1;
        applyStimulus(3, 1);
        n = 0;
        while (!cell_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("first_latency", 64'(cyc - req_cyc), 64'(RAM_LATENCY + 3));
        wait_drain("row3_drain", 1000);
        checkOutput("row3_rden_count", 64'(rden_count - base), 64'd1);

        // Row beyond the RAM: blank cells and no read strobe.
        base = rden_count;
        applyStimulus(60, 1);
        wait_drain("row60_drain", 1000);
        checkOutput("row60_no_rden", 64'(rden_count - base), 64'd0);

        // Three requests on consecutive cycles while the stream is stalled.
        ready_mode = 0;
        @(posedge clk);
        #1;
        base = overrun_count;
        applyStimulus(5, 1);
        applyStimulus(6, 1);
        applyStimulus(7, 0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("overrun_pulses", 64'(overrun_count - base), 64'd1);
        checkOutput("stalled_front_row", 64'({cell_valid, cell_row, cell_col}), 64'({1'b1, 8'd5, 8'd0}));
        ready_mode = 1;
        found = 1'b0;
        n = 0;
        while (!found && n < 300) begin
            @(negedge clk);
            n++;
            if (cell_valid && cell_ready && cell_last && cell_row == 8'd5) found = 1'b1;
        end
        checkOutput("row5_end_seen", 64'(found), 64'd1);
        @(negedge clk);
        checkOutput("no_bubble_row6", 64'({cell_valid, cell_row, cell_col}), 64'({1'b1, 8'd6, 8'd0}));
        wait_drain("rows56_drain", 1000);

        // Toggling ready: every unaccepted cell must stay stable.
        ready_mode = 2;
        applyStimulus($urandom_range(0, ROWS - 1), 1);
        wait_drain("toggle_drain", 1000);
        ready_mode = 1;

        // Reset while the FSM waits on the RAM for row 2.
        applyStimulus(2, 1);
        n = 0;
        while (!ram_rden && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("row2_rden_seen", 64'(ram_rden), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("midfetch_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(4, 1);
        wait_drain("row4_after_reset_drain", 1000);

        // Random rows, random ready and random gaps. A new request is issued
        // only when at most one row is still outstanding, so no request is
        // dropped.
        base = overrun_count;
        ready_mode = 3;
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 40)) @(posedge clk);
            #1;
            n = 0;
            while (exp_q.size() > COLUMNS && n < 2000) begin
                @(posedge clk);
                #1;
                n++;
            end
            row = $urandom_range(0, 63);
            applyStimulus(row, 1);
        end
        wait_drain("random_drain", 4000);
        checkOutput("random_no_overrun", 64'(overrun_count - base), 64'd0);

        // Cursor at (3,10): reverse video only when the overlay is built in
        // and cursor_on is set.
        ready_mode = 1;
        cursor_row = 8'd3;
        cursor_col = 8'd10;
        cursor_on  = 1'b1;
        applyStimulus(3, 1);
        wait_drain("cursor_on_drain", 1000);
        cursor_on = 1'b0;
        applyStimulus(3, 1);
        wait_drain("cursor_off_drain", 1000);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
